// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// The optional zero-operand bypass is selected in mult_seq by MULT_ZERO_BYPASS_EN.
package mult_pkg;

   localparam int MULT_N = 8;
   localparam int MULT_CNT_W = $clog2(MULT_N);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Iteration counter width; n >= 2 keeps this at least one bit.
   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mult_seq_add.sv
// Parameterised n-bit ripple-carry adder with explicit carry-in and carry-out
// of the top stage; the multiplier reuses one instance for every iteration.
module add #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         ci_i,
   output logic [N-1:0] sum_o,
   output logic         co_o
);

   logic [N:0] carry;

   assign carry[0] = ci_i;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign co_o = carry[N];

endmodule

// File: rtl/mult_seq.sv
// Sequential unsigned NxN shift-add multiplier: one add/shift per clock, 2N-bit
// product with a one-cycle done pulse. Define MULT_ZERO_BYPASS_EN to skip RUN on zero operands.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start_i; outputs hold last product
// ST_RUN  | one add/shift iteration per cycle, busy_o high
// ST_DONE | product valid, done_o high for this single cycle; accepts start_i
module mult_seq
   import mult_pkg::*;
#(
   parameter int N = MULT_N
) (
   input  logic           clk_i,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [N-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   output logic [2*N-1:0] p_o,
   output logic           busy_o,
   output logic           done_o
);

   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

   state_e           state_q;
   logic [N-1:0]     mcand_q;
   logic [N-1:0]     hi_q;
   logic [N-1:0]     lo_q;
   logic             c_q;
   logic [CW-1:0]    cnt_q;
   logic [2*N-1:0]   p_q;
   logic             busy_q;
   logic             done_q;

   logic [N-1:0]     sum;
   logic             co;
   logic [N-1:0]     hi_d;
   logic             c_d;
   logic             zero_op;

   add #(.N(N)) u_add (
      .a_i   (hi_q),
      .b_i   (mcand_q),
      .ci_i  (1'b0),
      .sum_o (sum),
      .co_o  (co)
   );

   // C is cleared by every shift, so the hold path carries zero into the top bit.
   assign {c_d, hi_d} = lo_q[0] ? {co, sum} : {c_q, hi_q};

`ifdef MULT_ZERO_BYPASS_EN
   assign zero_op = (a_i == '0) || (b_i == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         p_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  mcand_q <= a_i;
                  hi_q    <= '0;
                  lo_q    <= b_i;
                  c_q     <= 1'b0;
                  cnt_q   <= '0;
                  if (zero_op) begin
                     state_q <= ST_DONE;
                     p_q     <= '0;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               c_q   <= 1'b0;
               hi_q  <= {c_d, hi_d[N-1:1]};
               lo_q  <= {hi_d[0], lo_q[N-1:1]};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  p_q     <= {c_d, hi_d, lo_q[N-1:1]};
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign p_o    = p_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq: a cycle-level acceptance model predicts products
// and done timing; a separate monitor checks every done pulse.
module tb_mult_seq;

   localparam int N = 8;
`ifdef MULT_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [2*N-1:0] p;
      int             cyc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   a_in;
   logic [N-1:0]   b_in;
   logic [2*N-1:0] p_o;
   logic           busy_o;
   logic           done_o;

   int nchk = 0;
   int nfail = 0;
   int cyc = 0;

   exp_t           sb[$];
   int             rem;
   logic [2*N-1:0] exp_p;
   logic [2*N-1:0] pend;

   mult_seq #(.N(N)) dut (
      .clk_i   (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .a_i     (a_in),
      .b_i     (b_in),
      .p_o     (p_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: the multiplier is unavailable for N edges after accepting a pair.
   task automatic step(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      @(negedge clk);
      start = s;
      a_in  = a;
      b_in  = b;
      @(posedge clk);
      #1;
      if (rem > 0) begin
         rem--;
         if (rem == 0) exp_p = pend;
      end else if (s) begin
         pend = (2*N)'(a) * (2*N)'(b);
         if (BYP && (a == 0 || b == 0)) begin
            exp_p = '0;
            e.p   = '0;
            e.cyc = cyc;
         end else begin
            rem   = N;
            e.p   = pend;
            e.cyc = cyc + N;
         end
         sb.push_back(e);
      end
      chk("busy", 64'(busy_o), 64'(rem > 0));
      chk("p_held", 64'(p_o), 64'(exp_p));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && done_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done_o), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("product", 64'(p_o), 64'(e.p));
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      rem   = 0;
      exp_p = '0;
      pend  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_p", 64'(p_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // 3 x 5, accepted on the first edge after reset release
      step(1'b1, 8'd3, 8'd5);
      idle(N + 1);
      chk("p_3x5", 64'(p_o), 64'h000F);
      chk("done_low_after", 64'(done_o), 64'd0);

      step(1'b1, 8'hFF, 8'hFF);
      idle(N + 1);
      chk("p_ffxff", 64'(p_o), 64'hFE01);

      // Start pulses during RUN must be ignored
      step(1'b1, 8'h11, 8'h22);
      step(1'b0, '0, '0);
      step(1'b1, 8'h55, 8'h66);
      step(1'b0, '0, '0);
      step(1'b0, '0, '0);
      step(1'b1, 8'h77, 8'h88);
      idle(N);
      chk("p_ignored_starts", 64'(p_o), 64'h0242);

      // Start held high: one product per N+1 cycles
      for (int i = 0; i < 3 * (N + 1); i++) step(1'b1, 8'h12, 8'h34);
      idle(N + 1);
      chk("p_held_start", 64'(p_o), 64'h03A8);

      // Asynchronous reset during RUN
      step(1'b1, 8'h05, 8'h06);
      idle(3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_p", 64'(p_o), 64'd0);
      chk("midrun_rst_busy", 64'(busy_o), 64'd0);
      chk("midrun_rst_done", 64'(done_o), 64'd0);
      rem   = 0;
      exp_p = '0;
      sb.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step(1'b1, 8'd7, 8'd9);
      idle(N + 1);
      chk("p_7x9", 64'(p_o), 64'h003F);

      // Zero operand: bypass build finishes at once, default build runs N cycles
      step(1'b1, 8'd0, 8'd7);
      idle(N + 1);
      chk("p_0x7", 64'(p_o), 64'd0);
      step(1'b1, 8'h9C, 8'd0);
      idle(N + 1);

      // Random traffic with biased operands
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] ra, rb;
         int ka, kb;
         ka = $urandom_range(0, 7);
         kb = $urandom_range(0, 7);
         ra = (ka == 0) ? '0 : (ka == 1) ? '1 : N'($urandom);
         rb = (kb == 0) ? '0 : (kb == 1) ? '1 : N'($urandom);
         step($urandom_range(0, 3) != 0, ra, rb);
      end

      for (int i = 0; i < 3 * N && sb.size() > 0; i++) step(1'b0, '0, '0);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
